// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings for the fetch unit: next-PC selects, branch funct3 codes and FSM states.
package pc_pkg;

   localparam int unsigned SEL_W = 2;
   localparam int unsigned F3_W  = 3;

   localparam logic [SEL_W-1:0] SEL_SEQ  = 2'b00;
   localparam logic [SEL_W-1:0] SEL_JAL  = 2'b01;
   localparam logic [SEL_W-1:0] SEL_JALR = 2'b10;
   localparam logic [SEL_W-1:0] SEL_MRET = 2'b11;

   localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
   localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
   localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
   localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
   localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
   localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

endpackage

// File: rtl/pc_fetch_unit_branch_cond.sv
// Conditional-branch resolution: funct3 plus ALU comparator flags to a taken bit.
module branch_cond
   import pc_pkg::*;
(
   input  logic            branch,
   input  logic [F3_W-1:0] funct3,
   input  logic            eq,
   input  logic            lt,
   input  logic            ltu,
   output logic            taken
);

   logic w_cond;

   // Reserved encodings 010/011 resolve to not-taken.
   always_comb begin
      w_cond = 1'b0;
      case (funct3)
         F3_BEQ:  w_cond = eq;
         F3_BNE:  w_cond = !eq;
         F3_BLT:  w_cond = lt;
         F3_BGE:  w_cond = !lt;
         F3_BLTU: w_cond = ltu;
         F3_BGEU: w_cond = !ltu;
         default: w_cond = 1'b0;
      endcase
   end

   assign taken = branch && w_cond;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC register and instruction-memory request handshake with execute-stage
// redirects, misaligned-target trapping and mret return.
module pc_fetch_unit
   import pc_pkg::*;
#(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
   parameter int unsigned     IALIGN       = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [XLEN-1:0]  imem_addr,
   output logic [XLEN-1:0]  pc_out,
   input  logic             ex_valid,
   input  logic [XLEN-1:0]  ex_pc,
   input  logic [SEL_W-1:0] next_pc_sel,
   input  logic             branch,
   input  logic [F3_W-1:0]  funct3,
   input  logic             eq,
   input  logic             lt,
   input  logic             ltu,
   input  logic [XLEN-1:0]  imm,
   input  logic [XLEN-1:0]  rs1,
   output logic [XLEN-1:0]  link_addr,
   output logic             redirect,
   output logic             flush,
   output logic             misalign_trap,
   output logic [XLEN-1:0]  mepc
);

   localparam logic [XLEN-1:0] SEQ_INC = XLEN'(4);

   state_t          r_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_mepc;
   logic [XLEN-1:0] r_pend;
   logic            r_pend_v;
   logic            r_trap;

   logic            w_valid;
   logic            w_accept;
   logic            w_hold;
   logic            w_taken;
   logic            w_redirect;
   logic            w_misalign;
   logic            w_trap;
   logic [XLEN-1:0] w_jalr_sum;
   logic [XLEN-1:0] w_target;
   logic [XLEN-1:0] w_new_pc;

   branch_cond u_branch_cond (
      .branch (branch),
      .funct3 (funct3),
      .eq     (eq),
      .lt     (lt),
      .ltu    (ltu),
      .taken  (w_taken)
   );

   // A request left unaccepted must keep its address, so redirects park in r_pend.
   assign w_valid    = !rst && (((r_state == REQ) && !stall) || (r_state == WAIT));
   assign w_accept   = w_valid && imem_req_ready;
   assign w_hold     = w_valid && !imem_req_ready;
   assign w_redirect = ex_valid && ((next_pc_sel != SEL_SEQ) || w_taken);
   assign w_jalr_sum = rs1 + imm;

   always_comb begin
      w_target = ex_pc + imm;
      case (next_pc_sel)
         SEL_JALR: w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
         SEL_MRET: w_target = r_mepc;
         default:  w_target = ex_pc + imm;
      endcase
   end

   assign w_misalign = (next_pc_sel != SEL_MRET) &&
                       ((IALIGN == 2) ? w_target[0] : w_target[1]);
   assign w_trap     = w_redirect && w_misalign;
   assign w_new_pc   = w_trap ? TRAP_VECTOR : w_target;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_pc     <= RESET_VECTOR;
         r_mepc   <= '0;
         r_pend   <= '0;
         r_pend_v <= 1'b0;
         r_trap   <= 1'b0;
      end else begin
         r_trap <= w_trap;
         if (w_trap) begin
            r_mepc <= ex_pc;
         end

         if (w_redirect) begin
            if (w_hold) begin
               r_pend   <= w_new_pc;
               r_pend_v <= 1'b1;
            end else begin
               r_pc     <= w_new_pc;
               r_pend_v <= 1'b0;
            end
         end else if (w_accept) begin
            if (r_pend_v) begin
               r_pc     <= r_pend;
               r_pend_v <= 1'b0;
            end else begin
               r_pc <= r_pc + SEQ_INC;
            end
         end

         case (r_state)
            IDLE:    r_state <= REQ;
            REQ:     r_state <= w_hold ? WAIT : REQ;
            WAIT:    r_state <= imem_req_ready ? REQ : WAIT;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign imem_req_valid = w_valid;
   assign imem_addr      = r_pc;
   assign pc_out         = r_pc;
   assign link_addr      = ex_pc + SEQ_INC;
   assign redirect       = w_redirect;
   assign flush          = w_redirect;
   assign misalign_trap  = r_trap && !rst;
   assign mepc           = r_mepc;

endmodule
